// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//
// Exhaustive stimulus engine for small combinational blocks. On start it
// drives every N_IN-bit input vector in ascending order. It holds each vector
// for HOLD_CYCLES cycles, then compares the DUT response against the EXPECTED
// truth table at the edge that ends the last hold cycle. It reports the
// mismatch count and the first failing vector.
//
// Optional build macro:
//   SWEEP_STOP_ON_FAIL_EN - the first mismatch ends the sweep at once, and
//                           stim stays on the failing vector.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   begin a sweep (sampled in IDLE or DONE only)
//   stim       out  N_IN   vector driven to the DUT, stim[N_IN-1] is the MSB
//   resp       in   N_OUT  DUT response
//   busy       out  high while vectors are being driven
//   done       out  sweep finished; sticky until the next start
//   pass       out  done with no mismatches
//   err_count  out  N_IN+1 mismatching vectors, saturating at 2**N_IN
//   fail_valid out  at least one mismatch seen this sweep
//   fail_vec   out  N_IN   first mismatching vector

module truth_table_sweeper #(
  parameter int N_IN        = 3,
  parameter int N_OUT       = 1,
  parameter int HOLD_CYCLES = 1,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic [N_OUT-1:0]  resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              fail_valid,
  output logic [N_IN-1:0]   fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
  // Saturation value 2**N_IN: the top bit of the counter set, all others clear.
  localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

  state_t            state_q, state_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [7:0]        hold_q, hold_d;
  logic [N_IN:0]     err_q, err_d;
  logic              fv_q, fv_d;
  logic [N_IN-1:0]   fvec_q, fvec_d;
  logic [N_OUT-1:0]  exp_slice;
  logic              mismatch;

  // Expected response for the vector currently on stim.
  assign exp_slice = EXPECTED[int'(stim_q) * N_OUT +: N_OUT];
  assign mismatch  = (resp != exp_slice);

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d = state_q;
    stim_d  = stim_q;
    hold_d  = hold_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          stim_d  = '0;
          hold_d  = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
        end
      end

      DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          // Compare edge: resp is only trusted here, after the hold time.
          if (mismatch) begin
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
            if (!fv_q) begin
              fv_d   = 1'b1;
              fvec_d = stim_q;
            end
          end
          // The last vector is all-ones; stim never wraps back to 0.
          if ((STOP_ON_FAIL && mismatch) || (&stim_q)) begin
            state_d = DONE;
          end else begin
            stim_d = stim_q + 1'b1;
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = (state_q == DRIVE);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_q == '0);
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Synthesisable, self-checking exhaustive stimulus engine for combinational lab blocks. On `start` it drives every input combination of an N-input DUT in ascending binary order, holds each vector for a programmable number of cycles, and samples and compares the DUT response against a parameterised expected truth table. It reports the mismatch count and the first failing vector. It sits beside the DUT in lab top-levels and benches, replacing hand-written `#20` stimulus lists.

## Interface
Parameters:
- `N_IN`, 3: DUT input count; legal range 1–16.
- `N_OUT`, 1: DUT output count; legal range 1–8.
- `HOLD_CYCLES`, 1: cycles each vector is held before sampling; legal range 1–255.
- `EXPECTED`, all zeros, width `(2**N_IN)*N_OUT`: expected response; vector v occupies `EXPECTED[v*N_OUT +: N_OUT]`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `stim`  out  N_IN  drive to DUT inputs; `stim[N_IN-1]` is the MSB (e.g. `a` of a,b,c).
- `resp`  in  N_OUT  DUT outputs.
- `busy`  out  1  high during DRIVE.
- `done`  out  1  high in DONE; sticky until next `start`.
- `pass`  out  1  `done && err_count==0`.
- `err_count`  out  N_IN+1  count of mismatching vectors, saturating at 2**N_IN.
- `fail_valid`  out  1  at least one mismatch recorded this sweep.
- `fail_vec`  out  N_IN  first mismatching vector; valid when `fail_valid`.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE → DRIVE on `start`: `stim`←0, hold counter←0, `err_count`/`fail_valid`/`fail_vec`←0, `done`←0.
- DRIVE: the hold counter counts 0..HOLD_CYCLES-1. At the edge ending the last hold cycle, compare `resp` with `EXPECTED` slice for `stim`, using the full N_OUT-bit equality.
- On mismatch: `err_count`++ (saturating). If `fail_valid` was 0, set it and latch `fail_vec`←`stim`.
- After a compare, if `stim` ≠ 2**N_IN−1: `stim`++ and the hold counter←0. Otherwise go to DONE.
- DONE: `stim` holds its last value. `start` restarts the sweep exactly as from IDLE. There is no path back to IDLE except reset.
- `start` during DRIVE is ignored; the sweep continues.
- `resp` is used only at compare edges. The DUT must settle within HOLD_CYCLES cycles.
- Reset (any time, including mid-sweep): state IDLE; `stim`, `busy`, `done`, `pass`, `err_count`, `fail_valid`, `fail_vec` all 0.

## Timing
- Start latency: `stim`=0 and `busy`=1 in the cycle after the edge that samples `start`.
- Vector v is on `stim` for exactly HOLD_CYCLES cycles. It is compared at the edge ending its last hold cycle.
- Full sweep: `done` rises (2**N_IN)·HOLD_CYCLES cycles after the start-accept edge. `busy` falls on the same edge.
- `err_count` and `fail_*` update on the compare edge. They are visible the following cycle.
- Wrap-around: `stim` never wraps to 0 within a sweep. The last vector is all-ones.
- `pass` is combinational from the registered `done` and `err_count`.

## Configuration
- `SWEEP_STOP_ON_FAIL_EN` defined:
  - The first mismatch transitions DRIVE → DONE on the compare edge.
  - `stim` stays at the failing vector.
  - `err_count`=1, `pass`=0.
- Not defined: the sweep always completes all 2**N_IN vectors and counts every mismatch.

## Test plan
Default parameters (N_IN=3, N_OUT=1, HOLD_CYCLES=1, EXPECTED=8'h31). DUT model y = (~b&~c)|(a&~b).

- Correct DUT, pulse `start` → `stim` steps 0..7 one per cycle; `done`=1 eight cycles after accept; `pass`=1, `err_count`=0, `fail_valid`=0.
- DUT with y forced 0 → `err_count`=3; `fail_vec`=3'b000; `pass`=0.
- HOLD_CYCLES=4, correct DUT → each `stim` value held 4 cycles; `done` at cycle 32; `start` pulses while `busy` have no effect.
- Assert `reset_n`=0 while `stim`=5 → all outputs 0 immediately (asynchronously); after release, a new `start` restarts from `stim`=0.
- `SWEEP_STOP_ON_FAIL_EN` defined, DUT wrong only at vector 6 (y=1) → `done` at cycle 7; `stim`=6, `err_count`=1, `fail_vec`=6.
- N_IN=4, N_OUT=2, EXPECTED all ones, DUT outputs 2'b11 → 16 vectors; `pass`=1; `err_count` width 5 holds 0.
